// File: rtl/sample_playback_ctrl_pkg.sv
// Shared types and default sizing for the sample playback controller.
// Holds the FSM state encoding and the default audio/RAM geometry.
// No logic lives here; every other file in the slice imports it.
package sampler_pkg;

  // Controller phases: idle, waiting for a frame tick, RAM fetch, codec handoff.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    FETCH     = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  // 50 MHz system clock divided down to ~44.1 kHz.
  localparam int CLK_DIV_DEF = 1134;
  // 16k frames per channel; the RAM address adds one bit selecting left/right.
  localparam int FRAME_W_DEF = 14;
  // Codec sample width.
  localparam int DATA_W_DEF  = 24;
  // Cycles from a stable RAM address to usable read data.
  localparam int RAM_LAT_DEF = 2;

endpackage

// File: rtl/sample_playback_ctrl_if.sv
// Bundle of control, RAM and codec signals around the playback controller.
// master is the controller side; slave is the environment (host, RAM, codec).
// Flow control is the codec write_ready/write handshake carried here.
interface sample_playback_ctrl_if
  import sampler_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  // Host control
  logic               play;
  logic               stop;
  logic               loop;
  logic [FRAME_W-1:0] start_addr;
  logic [FRAME_W-1:0] end_addr;

  // Dual-port audio RAM: left half at {0,idx}, right half at {1,idx}
  logic [FRAME_W:0]   ram_addr_l;
  logic [FRAME_W:0]   ram_addr_r;
  logic [DATA_W-1:0]  ram_q_l;
  logic [DATA_W-1:0]  ram_q_r;

  // Codec write path
  logic               write_ready;
  logic               write;
  logic [DATA_W-1:0]  audio_l;
  logic [DATA_W-1:0]  audio_r;

  // Status
  logic               busy;
  logic               done;
  logic               underrun;

  modport master (
    input  play, stop, loop, start_addr, end_addr,
    input  ram_q_l, ram_q_r, write_ready,
    output ram_addr_l, ram_addr_r, write, audio_l, audio_r,
    output busy, done, underrun
  );

  modport slave (
    output play, stop, loop, start_addr, end_addr,
    output ram_q_l, ram_q_r, write_ready,
    input  ram_addr_l, ram_addr_r, write, audio_l, audio_r,
    input  busy, done, underrun
  );

endinterface

// File: rtl/sample_playback_ctrl_tick.sv
// Free-running frame-rate divider: one-cycle tick every CLK_DIV clocks.
// First tick lands CLK_DIV cycles after reset release; registered output.
// No backpressure: the tick runs regardless of what the controller is doing.
module sample_rate_tick
  import sampler_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLK_DIV-1 and emit the tick on the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sample_playback_ctrl.sv
// Plays one stereo sample out of the audio RAM into the codec, one frame per tick.
// Latency: tick at T -> frame presented at T+RAM_LAT+1, write strobe one cycle after acceptance.
// Backpressure: a frame is held in PRESENT until write_ready; a tick missed there flags underrun.
module sample_playback_ctrl
  import sampler_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = RAM_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_playback_ctrl_if.master bus
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_LAT - 1);

  logic tick;

  sample_rate_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] idx, idx_nxt;
  logic [FRAME_W-1:0] start_q, start_nxt;
  logic [FRAME_W-1:0] end_q, end_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic               pending, pending_nxt;
  // Set for the single cycle after the last non-loop frame is accepted, so the
  // write/done strobes still see the frame on the audio outputs and busy=1.
  logic               finish, finish_nxt;
  logic [DATA_W-1:0]  audio_l_q, audio_l_nxt;
  logic [DATA_W-1:0]  audio_r_q, audio_r_nxt;
  logic               write_q, write_nxt;
  logic               done_q, done_nxt;
  logic               underrun_q, underrun_nxt;
  logic [FRAME_W:0]   addr_l_q, addr_r_q;

  // State and datapath registers; RAM addresses trail idx by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      start_q    <= '0;
      end_q      <= '0;
      lat_cnt    <= '0;
      pending    <= 1'b0;
      finish     <= 1'b0;
      audio_l_q  <= '0;
      audio_r_q  <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      addr_l_q   <= '0;
      addr_r_q   <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      start_q    <= start_nxt;
      end_q      <= end_nxt;
      lat_cnt    <= lat_nxt;
      pending    <= pending_nxt;
      finish     <= finish_nxt;
      audio_l_q  <= audio_l_nxt;
      audio_r_q  <= audio_r_nxt;
      write_q    <= write_nxt;
      done_q     <= done_nxt;
      underrun_q <= underrun_nxt;
      addr_l_q   <= {1'b0, idx};
      addr_r_q   <= {1'b1, idx};
    end
  end

  // Next-state logic: stop beats play, play beats everything else.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    start_nxt    = start_q;
    end_nxt      = end_q;
    lat_nxt      = lat_cnt;
    pending_nxt  = pending;
    finish_nxt   = finish;
    audio_l_nxt  = audio_l_q;
    audio_r_nxt  = audio_r_q;
    write_nxt    = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = underrun_q;

    if (bus.stop) begin
      state_nxt   = IDLE;
      pending_nxt = 1'b0;
      finish_nxt  = 1'b0;
      audio_l_nxt = '0;
      audio_r_nxt = '0;
    end else if (bus.play) begin
      // Retrigger: restart from start_addr; underrun history is kept.
      state_nxt   = WAIT_TICK;
      idx_nxt     = bus.start_addr;
      start_nxt   = bus.start_addr;
      end_nxt     = bus.end_addr;
      pending_nxt = 1'b0;
      finish_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          audio_l_nxt = '0;
          audio_r_nxt = '0;
        end

        WAIT_TICK: begin
          if (tick || pending) begin
            state_nxt   = FETCH;
            lat_nxt     = LAT_LOAD;
            pending_nxt = 1'b0;
          end
        end

        FETCH: begin
          // idx is frozen here, so the RAM address is stable for the whole fetch.
          if (tick) begin
            pending_nxt = 1'b1;
          end
          if (lat_cnt == '0) begin
            audio_l_nxt = bus.ram_q_l;
            audio_r_nxt = bus.ram_q_r;
            state_nxt   = PRESENT;
          end else begin
            lat_nxt = lat_cnt - 1'b1;
          end
        end

        PRESENT: begin
          if (finish) begin
            state_nxt   = IDLE;
            finish_nxt  = 1'b0;
            pending_nxt = 1'b0;
            audio_l_nxt = '0;
            audio_r_nxt = '0;
          end else if (bus.write_ready) begin
            write_nxt = 1'b1;
            if (tick) begin
              pending_nxt = 1'b1;
            end
            if (idx != end_q) begin
              // Modulo 2^FRAME_W increment; end is found by equality only.
              idx_nxt   = idx + 1'b1;
              state_nxt = WAIT_TICK;
            end else if (bus.loop) begin
              idx_nxt   = start_q;
              state_nxt = WAIT_TICK;
            end else begin
              done_nxt   = 1'b1;
              finish_nxt = 1'b1;
            end
          end else if (tick) begin
            // Codec fell behind the frame rate; keep the frame, flag it.
            underrun_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr_l = addr_l_q;
  assign bus.ram_addr_r = addr_r_q;
  assign bus.write      = write_q;
  assign bus.done       = done_q;
  assign bus.audio_l    = audio_l_q;
  assign bus.audio_r    = audio_r_q;
  assign bus.busy       = (state != IDLE);
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_sample_playback_ctrl.sv
// Scoreboard bench for sample_playback_ctrl with a fast frame tick.
// Expected frames are queued when play is driven and checked on each write strobe.
// RAM model returns its own address one clock after it is presented.
module tb_sample_playback_ctrl;
  import sampler_pkg::*;

  localparam int FW      = 14;
  localparam int DW      = 24;
  localparam int CLK_DIV = 8;
  localparam int RAM_LAT = 2;
  localparam int RIGHT   = 1 << FW;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sample_playback_ctrl_if #(.FRAME_W(FW), .DATA_W(DW)) bus ();

  sample_playback_ctrl #(
    .CLK_DIV (CLK_DIV),
    .FRAME_W (FW),
    .DATA_W  (DW),
    .RAM_LAT (RAM_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data = address, valid RAM_LAT-1 clocks after the address settles.
  always @(posedge clk) begin
    bus.ram_q_l <= DW'(bus.ram_addr_l);
    bus.ram_q_r <= DW'(bus.ram_addr_r);
  end

  typedef struct {
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  bit   busy_chk = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push_seq(input int s, input int n, input bit last_at_end);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = (s + i) % RIGHT;
      e.last = last_at_end && (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_play(input int s, input int e);
    @(negedge clk);
    bus.start_addr = FW'(s);
    bus.end_addr   = FW'(e);
    bus.play       = 1'b1;
    @(negedge clk);
    bus.play       = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.busy, 0);
  endtask

  // Write-side monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy_chk) begin
        chk("busy_after_done", bus.busy, 0);
        busy_chk = 1'b0;
      end
      if (bus.write) begin
        exp_t e;
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("write_expected", sb.size() > 0, 1);
        end else begin
          e = sb.pop_front();
          chk("audio_l", bus.audio_l, e.idx);
          chk("audio_r", bus.audio_r, RIGHT + e.idx);
          chk("done_with_write", bus.done, e.last);
          if (e.last) busy_chk = 1'b1;
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (!bus.write) chk("done_without_write", bus.write, 1);
      end
    end
  end

  initial begin
    int n;
    int w0;
    int d0;

    bus.play        = 1'b0;
    bus.stop        = 1'b0;
    bus.loop        = 1'b0;
    bus.start_addr  = '0;
    bus.end_addr    = '0;
    bus.write_ready = 1'b1;

    // 1. Reset values and first tick
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write",    bus.write, 0);
    chk("rst_done",     bus.done, 0);
    chk("rst_busy",     bus.busy, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_audio_l",  bus.audio_l, 0);
    chk("rst_audio_r",  bus.audio_r, 0);
    chk("rst_addr_l",   bus.ram_addr_l, 0);
    chk("rst_addr_r",   bus.ram_addr_r, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!dut.u_tick.tick && n < 30);
    chk("first_tick", n, CLK_DIV);

    // 2. Single non-loop play
    push_seq(4, 3, 1'b1);
    pulse_play(4, 6);
    chk("t2_busy", bus.busy, 1);
    wait_idle("t2_idle", 200);
    chk("t2_frames", sb.size(), 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3. Loop: 10,11,10,11 with no done, then stop
    d0 = done_cnt;
    bus.loop = 1'b1;
    push_seq(10, 2, 1'b0);
    push_seq(10, 2, 1'b0);
    pulse_play(10, 11);
    wait_sb("t3_frames", 200);
    pulse_stop();
    bus.loop = 1'b0;
    chk("t3_stopped", bus.busy, 0);
    chk("t3_no_done", done_cnt, d0);

    // 4. Underrun: codec stalls across a tick
    chk("t4_underrun_pre", bus.underrun, 0);
    bus.write_ready = 1'b0;
    push_seq(20, 2, 1'b1);
    pulse_play(20, 21);
    n = 0;
    while (bus.audio_l != 20 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t4_present", bus.audio_l, 20);
    w0 = wr_cnt;
    repeat (CLK_DIV + 2) @(negedge clk);
    chk("t4_underrun", bus.underrun, 1);
    chk("t4_hold_l", bus.audio_l, 20);
    chk("t4_hold_r", bus.audio_r, RIGHT + 20);
    chk("t4_no_write", wr_cnt, w0);
    bus.write_ready = 1'b1;
    wait_idle("t4_idle", 200);
    chk("t4_frames", sb.size(), 0);
    chk("t4_underrun_sticky", bus.underrun, 1);

    // 5. Stop in the middle of a fetch
    push_seq(30, 1, 1'b0);
    pulse_play(30, 35);
    wait_sb("t5_first", 100);
    n = 0;
    while (dut.state != FETCH && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_fetch", dut.state == FETCH, 1);
    chk("t5_audio_pre", bus.audio_l, 30);
    w0 = wr_cnt;
    d0 = done_cnt;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("t5_idle", bus.busy, 0);
    chk("t5_audio_l0", bus.audio_l, 0);
    chk("t5_audio_r0", bus.audio_r, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_write", wr_cnt, w0);
    chk("t5_no_done", done_cnt, d0);

    // stop and play together: stop wins
    @(negedge clk);
    bus.start_addr = FW'(40);
    bus.end_addr   = FW'(41);
    bus.play       = 1'b1;
    bus.stop       = 1'b1;
    @(negedge clk);
    bus.play       = 1'b0;
    bus.stop       = 1'b0;
    chk("t5_stop_wins", bus.busy, 0);
    repeat (20) @(negedge clk);
    chk("t5_still_idle", bus.busy, 0);
    chk("t5_no_write2", wr_cnt, w0);

    // 6a. Wrap through zero
    push_seq(16382, 4, 1'b1);
    pulse_play(16382, 1);
    wait_idle("t6_wrap_idle", 300);
    chk("t6_wrap_frames", sb.size(), 0);

    // 6b. Retrigger mid-sample
    push_seq(200, 1, 1'b0);
    pulse_play(200, 205);
    wait_sb("t6_first", 100);
    push_seq(100, 2, 1'b1);
    pulse_play(100, 101);
    wait_idle("t6_retrig_idle", 200);
    chk("t6_retrig_frames", sb.size(), 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sample_playback_ctrl.md
# sample_playback_ctrl

- Sequences one stereo sample stored in the dual-port 24-bit audio RAM.
- Generates the ~44.1 kHz frame tick, issues left/right frame addresses, waits out RAM read latency and presents each frame to the audio codec write path.
- Handshakes with the codec via `write_ready`.
- Handles play, stop, retrigger, loop and end-of-sample; replaces the free-running address counters between the RAM and the codec.

## Interface
- `CLK_DIV`, default 1134: clk cycles per frame tick (50 MHz / 44.1 kHz).
- `FRAME_W`, default 14: frame index width. RAM address is FRAME_W+1 bits.
- `DATA_W`, default 24: sample width.
- `RAM_LAT`, default 2: RAM read latency in clk cycles, ≥1.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `play` in 1: one-cycle start/retrigger pulse.
- `stop` in 1: one-cycle stop pulse.
- `loop` in 1: level; wrap to `start_addr` at end.
- `start_addr` in FRAME_W: first frame, sampled on `play`.
- `end_addr` in FRAME_W: last frame, sampled on `play`.
- `ram_addr_l` out FRAME_W+1: {1'b0, idx}.
- `ram_addr_r` out FRAME_W+1: {1'b1, idx}.
- `ram_q_l` in DATA_W: RAM port A read data.
- `ram_q_r` in DATA_W: RAM port B read data.
- `write_ready` in 1: codec can accept a frame.
- `write` out 1: one-cycle frame-accepted strobe.
- `audio_l` out DATA_W: current left sample.
- `audio_r` out DATA_W: current right sample.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last frame, non-loop only.
- `underrun` out 1: sticky; tick arrived while a frame was still unaccepted.

## Operation
- **States:**
  - IDLE: outputs zeroed; `play` → WAIT_TICK.
  - WAIT_TICK: wait for tick or pending tick → FETCH.
  - FETCH: count down RAM_LAT, capture RAM data → PRESENT.
  - PRESENT: hold frame until `write_ready`.
- **`play` in any state** loads idx=`start_addr`, latches `end_addr`, clears `pending`, goes to WAIT_TICK. This is a retrigger; `underrun` is not cleared.
- **`stop` in any state** → IDLE next cycle: audio zeroed, no `write`, no `done`. `stop` wins over a same-cycle `play`.
- **PRESENT with `write_ready`=1:** `write`=1 the next cycle. Then:
  - idx≠end: idx advances and the block returns to WAIT_TICK.
  - idx=end, `loop`=1: idx=start, return to WAIT_TICK.
  - idx=end, `loop`=0: `done` pulses the next cycle and the block goes to IDLE.
- **Index arithmetic:** idx increments modulo 2^FRAME_W and end is detected by equality only. end<start therefore wraps through 0. start=end plays one frame.
- **Tick in PRESENT without acceptance:** `underrun`←1 (cleared only by `reset`); the frame is held and not dropped.
- **Tick in the same cycle as acceptance:** set `pending`, so WAIT_TICK exits on the next cycle.
- **Tick in FETCH:** sets `pending`.
- **Audio hold:** `audio_l`/`audio_r` keep the last captured frame in WAIT_TICK/FETCH; they are zero in IDLE.

## Timing
- **Reset values:** state IDLE. All outputs 0. idx=0. Divider count 0, `pending` 0.
- **Tick:**
  - One-cycle pulse, free-running, independent of state; reset only by `reset`.
  - First tick is CLK_DIV cycles after `reset` deasserts, then every CLK_DIV cycles.
- **Fetch latency:**
  - Tick sampled in WAIT_TICK at cycle T → FETCH for cycles T+1..T+RAM_LAT.
  - `ram_q_*` captured at the end of T+RAM_LAT.
  - Audio valid and state PRESENT at T+RAM_LAT+1.
- **Addresses:** `ram_addr_*` change only on the cycle after idx changes. They are stable for all of FETCH because idx never changes inside FETCH.
- **Write strobe:** `write_ready` sampled high in PRESENT at cycle W → `write`=1 at W+1, with audio still holding that frame.
- **Done:** `done` is the same cycle as the final `write`; `busy`=0 from W+2.

## Structure
- `sampler_pkg`:
  - state enum {IDLE, WAIT_TICK, FETCH, PRESENT};
  - FRAME_W/DATA_W defaults;
  - CLK_DIV default.
- Sub-module `sample_rate_tick` (parameter CLK_DIV; ports `clk`, `reset`, `tick`): the free-running divider.
- FSM, idx, latency counter and output registers live in the top module.

## Test plan
Bench settings: CLK_DIV=8, RAM_LAT=2, RAM model returning data=address.
1. **Reset:** hold `reset` 3 cycles → all outputs 0, `busy`=0, first tick 8 cycles after release.
2. **Single play:** `play` with start=4, end=6, loop=0, `write_ready`=1 → three `write` strobes with audio_l=4,5,6 and audio_r=16388,16389,16390. `done` with the third strobe; `busy`=0 after.
3. **Loop:** start=10, end=11, loop=1 → accepted sequence 10,11,10,11; no `done`.
4. **Underrun:** `write_ready`=0 across a tick → `underrun`=1, audio held. Raise `write_ready` → `write`, idx advances, `underrun` stays 1.
5. **Stop mid-FETCH:** `stop` → IDLE next cycle, audio 0, no `write`/`done`. `stop`+`play` in the same cycle → remains IDLE.
6. **Wrap and retrigger:**
   - start=16382, end=1 → 16382,16383,0,1.
   - `play` mid-sample with start=100 → next accepted frame is 100.
